// File: rtl/rtc_timer.sv
// rtc_timer: memory-mapped machine timer on the core data bus.
//
// It holds a 64-bit mtime counter that advances on prescaler ticks and a
// 64-bit mtimecmp compare register. It raises a level interrupt while
// IE is set and mtime >= mtimecmp.
//
// Register map (byte offset from BASE, addr[1:0] ignored):
//   0x00 MTIME_LO   0x04 MTIME_HI (returns the shadow latched by MTIME_LO)
//   0x08 CMP_LO     0x0C CMP_HI
//   0x10 CTRL       bit0 RUN, bit1 IE
//   0x14 PRESC      [15:0] prescaler reload
//   0x18, 0x1C      read 0, writes ignored
//
// Bus handshake: there is no back-pressure. A cycle with en high and addr
// inside the 32-byte BASE window is one complete access. A write
// (write != 0) takes effect at that edge. A read (write == 0) presents
// data on data_o after that edge. data_o is 0 after any other cycle.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   en      bus access strobe
//   write   byte write enables, 4'b0000 = read
//   addr    bus address
//   data_i  write data
//   data_o  registered read data
//   mti     registered machine-timer interrupt (level)
module rtc_timer #(
    parameter logic [31:0] BASE      = 32'h80006000,
    parameter logic [15:0] PRESC_RST = 16'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  write,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        mti
);

    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_PRESC    = 3'd5;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] hi_shadow;
    logic        run;
    logic        ie;
    logic [15:0] presc;
    logic [15:0] pcnt;

    logic        sel;
    logic [2:0]  off;
    logic        wr_en;
    logic        rd_en;
    logic        tick;
    logic [31:0] rdata;
    logic [31:0] ctrl_new;
    logic [31:0] presc_new;
    logic        unused_bits;

    assign sel   = en && (addr[31:5] == BASE[31:5]);
    assign off   = addr[4:2];
    assign wr_en = sel && (write != 4'b0000);
    assign rd_en = sel && (write == 4'b0000);
    assign tick  = run && (pcnt == presc);

    // Byte-address bits are not decoded.
    assign unused_bits = ^addr[1:0];

    // Replace only the enabled byte lanes of cur with wdata.
    function automatic logic [31:0] merge(input logic [31:0] cur,
                                          input logic [31:0] wdata,
                                          input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

    assign ctrl_new  = merge({30'd0, ie, run}, data_i, write);
    assign presc_new = merge({16'd0, presc}, data_i, write);

    // A bus write to either half of mtime overrides the tick for the
    // whole counter in that cycle. The unwritten half keeps its value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime <= 64'd0;
        end else if (wr_en && off == OFF_MTIME_LO) begin
            mtime[31:0] <= merge(mtime[31:0], data_i, write);
        end else if (wr_en && off == OFF_MTIME_HI) begin
            mtime[63:32] <= merge(mtime[63:32], data_i, write);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            run      <= 1'b0;
            ie       <= 1'b0;
            presc    <= PRESC_RST;
        end else if (wr_en) begin
            case (off)
                OFF_CMP_LO: mtimecmp[31:0]  <= merge(mtimecmp[31:0], data_i, write);
                OFF_CMP_HI: mtimecmp[63:32] <= merge(mtimecmp[63:32], data_i, write);
                OFF_CTRL: begin
                    run <= ctrl_new[0];
                    ie  <= ctrl_new[1];
                end
                OFF_PRESC:  presc <= presc_new[15:0];
                default:    ;
            endcase
        end
    end

    // Any CTRL or PRESC write restarts the prescaler phase. This puts the
    // first tick exactly PRESC+1 edges after the write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= 16'd0;
        end else if (wr_en && (off == OFF_CTRL || off == OFF_PRESC)) begin
            pcnt <= 16'd0;
        end else if (run) begin
            pcnt <= tick ? 16'd0 : pcnt + 16'd1;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (off)
            OFF_MTIME_LO: rdata = mtime[31:0];
            OFF_MTIME_HI: rdata = hi_shadow;
            OFF_CMP_LO:   rdata = mtimecmp[31:0];
            OFF_CMP_HI:   rdata = mtimecmp[63:32];
            OFF_CTRL:     rdata = {30'd0, ie, run};
            OFF_PRESC:    rdata = {16'd0, presc};
            default:      rdata = 32'd0;
        endcase
    end

    // Reading MTIME_LO snapshots the upper half. A following MTIME_HI read
    // then pairs with it, even if the low half wrapped in between.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_o    <= 32'd0;
            hi_shadow <= 32'd0;
            mti       <= 1'b0;
        end else begin
            data_o <= rd_en ? rdata : 32'd0;
            if (rd_en && off == OFF_MTIME_LO) hi_shadow <= mtime[63:32];
            mti <= ie && (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_rtc_timer.sv
// tb_rtc_timer: directed self-checking bench for rtc_timer.
//
// Read expectations are queued when a read is driven. The monitor pops one
// entry and compares it with data_o one step after each sampled read edge.
// Interrupt-line and reset checks are compared directly at the point in the
// sequence where they apply.
module tb_rtc_timer;

    localparam logic [31:0] BASE     = 32'h80006000;
    localparam logic [31:0] R_MLO    = 32'h00;
    localparam logic [31:0] R_MHI    = 32'h04;
    localparam logic [31:0] R_CLO    = 32'h08;
    localparam logic [31:0] R_CHI    = 32'h0C;
    localparam logic [31:0] R_CTRL   = 32'h10;
    localparam logic [31:0] R_PRESC  = 32'h14;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  write;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        mti;

    logic [31:0] exp_q[$];
    string       name_q[$];
    int          checks;
    int          failures;

    rtc_timer #(.BASE(BASE), .PRESC_RST(16'd1000)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .write  (write),
        .addr   (addr),
        .data_i (data_i),
        .data_o (data_o),
        .mti    (mti)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard compare ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every read edge on the bus yields one data_o value to check.
    always @(posedge clk) begin
        if (reset && en && write == 4'b0000) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL monitor: read seen with empty expect queue, data_o=%0h", data_o);
            end else begin
                check(name_q.pop_front(), {32'd0, data_o}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Each task is entered on a falling edge and consumes one rising edge.
    task automatic bus_write(input logic [31:0] off, input logic [31:0] data,
                             input logic [3:0] be);
        en = 1'b1; write = be; addr = BASE | off; data_i = data;
        @(negedge clk);
        en = 1'b0; write = 4'b0000; addr = 32'd0; data_i = 32'd0;
    endtask

    task automatic bus_read_addr(input logic [31:0] a, input logic [31:0] exp,
                                 input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        en = 1'b1; write = 4'b0000; addr = a;
        @(negedge clk);
        en = 1'b0; addr = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] off, input logic [31:0] exp,
                            input string name);
        bus_read_addr(BASE | off, exp, name);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; en = 1'b0; write = 4'b0000; addr = 32'd0; data_i = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset state
        check("rst_mti", {63'd0, mti}, 64'd0);
        check("rst_data_o", {32'd0, data_o}, 64'd0);
        bus_read(R_MLO,   32'h0,        "rst_mtime_lo");
        bus_read(R_MHI,   32'h0,        "rst_mtime_hi");
        bus_read(R_CLO,   32'hFFFFFFFF, "rst_cmp_lo");
        bus_read(R_CHI,   32'hFFFFFFFF, "rst_cmp_hi");
        bus_read(R_CTRL,  32'h0,        "rst_ctrl");
        bus_read(R_PRESC, 32'd1000,     "rst_presc");
        bus_read(32'h18,  32'h0,        "rst_res18");
        bus_read(32'h1C,  32'h0,        "rst_res1c");
        bus_read_addr(BASE + 32'h20, 32'h0, "out_of_window");

        // Prescaler: P=3, ticks every 4 edges after the RUN write
        bus_write(R_PRESC, 32'd3, 4'hF);
        bus_write(R_CTRL, 32'd1, 4'hF);
        idle(40);
        bus_read(R_MLO, 32'd10, "presc_after40");
        bus_read(R_MLO, 32'd10, "presc_hold1");
        bus_read(R_MLO, 32'd10, "presc_hold2");
        bus_read(R_MLO, 32'd10, "presc_hold3");
        bus_read(R_MLO, 32'd11, "presc_next_tick");
        bus_write(R_CTRL, 32'd0, 4'hF);

        // Byte enables over all-ones reset value
        bus_write(R_CLO, 32'h11223344, 4'b0101);
        check("data_o_after_write", {32'd0, data_o}, 64'd0);
        bus_read(R_CLO, 32'hFF22FF44, "byte_enable");

        // Atomic 64-bit read across a low-word wrap
        bus_write(R_PRESC, 32'd0, 4'hF);
        bus_write(R_MLO, 32'hFFFFFFFF, 4'hF);
        bus_write(R_MHI, 32'h0, 4'hF);
        bus_write(R_CTRL, 32'd1, 4'hF);
        bus_read(R_MLO, 32'hFFFFFFFF, "atomic_lo");
        bus_read(R_MHI, 32'h0,        "atomic_hi_shadow");
        bus_read(R_MLO, 32'h1,        "atomic_lo2");
        bus_read(R_MHI, 32'h1,        "atomic_hi2");

        // Interrupt
        bus_write(R_CTRL, 32'd0, 4'hF);
        bus_write(R_MLO, 32'd0, 4'hF);
        bus_write(R_MHI, 32'd0, 4'hF);
        bus_write(R_CHI, 32'd0, 4'hF);
        bus_write(R_CLO, 32'd20, 4'hF);
        bus_write(R_CTRL, 32'd3, 4'hF);
        idle(20);
        check("mti_before_cmp", {63'd0, mti}, 64'd0);
        idle(1);
        check("mti_rise", {63'd0, mti}, 64'd1);
        bus_write(R_CLO, 32'd100, 4'hF);
        check("mti_hold_at_cmp_write", {63'd0, mti}, 64'd1);
        idle(1);
        check("mti_fall", {63'd0, mti}, 64'd0);
        bus_write(R_CTRL, 32'd1, 4'hF);
        idle(100);
        check("mti_masked", {63'd0, mti}, 64'd0);
        bus_read(R_MLO, 32'd124, "mtime_past_100");

        // Write collides with a tick: the written value wins, the tick is lost
        bus_write(R_MLO, 32'd5, 4'hF);
        bus_read(R_MLO, 32'd5, "collision_first");
        idle(2);
        bus_read(R_MLO, 32'd8, "collision_later");
        bus_write(R_CTRL, 32'd3, 4'hF);
        bus_write(R_CLO, 32'd0, 4'hF);
        idle(1);
        bus_read(R_MLO, 32'd12, "pre_reset_read");
        check("pre_reset_mti", {63'd0, mti}, 64'd1);

        // Asynchronous reset between clock edges
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_mti", {63'd0, mti}, 64'd0);
        check("async_rst_data_o", {32'd0, data_o}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        bus_read(R_MLO,  32'h0,        "post_rst_mtime_lo");
        bus_read(R_MHI,  32'h0,        "post_rst_mtime_hi");
        bus_read(R_CTRL, 32'h0,        "post_rst_ctrl");
        bus_read(R_CLO,  32'hFFFFFFFF, "post_rst_cmp_lo");

        // Drain: bounded wait for the monitor to consume all expectations
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d reads not observed, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtc_timer.md
# rtc_timer

Memory-mapped machine timer that sits on the core's data bus beside the RAM and drives the machine-timer interrupt line into the core's IRQ vector. It holds a 64-bit `mtime` counter advanced by a programmable prescaler, a 64-bit `mtimecmp` compare register, and a control register. It raises `mti` while `mtime >= mtimecmp`. It replaces the ad-hoc bench timer register with synthesizable logic.

## Interface
- `BASE`, default 32'h80006000: base address, aligned to 32 bytes; the block decodes `addr[31:5] == BASE[31:5]`.
- `PRESC_RST`, default 16'd1000: reset value of the prescaler reload.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: data-bus access strobe from the core (`enable`).
- `write` in 4: byte write enables; 0 means a read.
- `addr` in 32: data-bus address (`DATA_address`).
- `data_i` in 32: write data (`DATA_out` of the core).
- `data_o` out 32: read data, registered.
- `mti` out 1: machine-timer interrupt, registered, level.

## Operation
- `sel = en && addr[31:5]==BASE[31:5]`. Offset is `addr[4:2]`; `addr[1:0]` is ignored.
- Register map:
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 CMP_LO
  - 0x0C CMP_HI
  - 0x10 CTRL: bit0 RUN, bit1 IE, others read 0
  - 0x14 PRESC: [15:0] reload, upper bits read 0
  - 0x18 and 0x1C: reads return 0, writes are ignored.
- Writes honour byte enables per byte lane. Partial writes modify only the enabled bytes.
- Prescaler:
  - 16-bit `pcnt`. When RUN=1 and `pcnt == PRESC`, `pcnt` goes to 0 and `tick` is asserted; otherwise `pcnt` increments.
  - When RUN=0, `pcnt` holds.
  - PRESC=0 gives a tick every cycle.
- `mtime` increments by 1 on `tick` and wraps from 2^64-1 to 0.
- Writing MTIME_LO or MTIME_HI in the same cycle as a tick: the written value wins for the written bytes; the increment is dropped for that cycle (the whole counter is not incremented).
- Writing PRESC or RUN clears `pcnt` to 0.
- Atomic read:
  - Reading MTIME_LO returns `mtime[31:0]` and latches `mtime[63:32]` into `hi_shadow` at the same edge.
  - Reading MTIME_HI returns `hi_shadow`, not the live value.
  - CMP reads are live.
- `data_o` is 0 on any cycle after which `sel && write==0` was false (matches the bus mux convention).
- `mti` is registered as `IE && (mtime >= mtimecmp)`, using an unsigned 64-bit compare on the register values in the current cycle.
- Reset values:
  - `mtime`=0, `pcnt`=0, `hi_shadow`=0
  - `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF
  - CTRL=0
  - PRESC=`PRESC_RST`
  - `data_o`=0, `mti`=0
- Reset assertion mid-operation immediately forces all of the above, asynchronously, including clearing `mti`.

## Timing
- Read latency is 1 cycle. With `sel`, `write==0` at edge N, `data_o` is valid after edge N and held until edge N+1.
- Write latency: with `sel`, `write!=0` at edge N, the register updates at edge N. A read issued at edge N+1 sees the new value.
- `mti` latency:
  - `mti` reflects the register state one edge later.
  - A CMP write at edge N that makes `mtime >= mtimecmp` sets `mti` at edge N+1.
  - A CMP write that raises `mtimecmp` above `mtime` clears `mti` at edge N+1.
- Tick cadence: with RUN=1 and PRESC=P, `mtime` increments every P+1 cycles. The first increment occurs P+1 edges after the RUN write edge.
- No back-pressure; every access completes in one bus cycle.
- Accesses outside the `BASE` window are ignored, and `data_o` is 0 on the following cycle.

## Test plan
- Reset check: hold `reset`=0, then release. Expect CMP_LO and CMP_HI to read 32'hFFFFFFFF, PRESC to read 1000, all other registers 0, and `mti`=0.
- Prescaler: write PRESC=3, then CTRL=1 (RUN). After 40 cycles, MTIME_LO reads 10; increments are observed exactly every 4 cycles.
- Atomic read: write MTIME_LO=32'hFFFFFFFF and MTIME_HI=0, with PRESC=0 and RUN=1.
  - Read MTIME_LO then MTIME_HI on consecutive cycles.
  - The LO read returns 32'hFFFFFFFF plus the elapsed count as of its edge.
  - The HI read returns the value latched by the LO read, not the later live value, even after a wrap.
- Byte enables: write CMP_LO=32'h11223344 with `write`=4'b0101 over a reset value of all ones. Expect a read of 32'hFF22FF44.
- Interrupt:
  - Set CMP_HI=0, CMP_LO=20, PRESC=0, CTRL=3. `mti` rises on the cycle after `mtime` reaches 20.
  - Write CMP_LO=100. `mti` falls one cycle after the write.
  - Clear IE. `mti` stays 0 even when `mtime` passes 100.
- Collision and reset mid-run:
  - With RUN=1, PRESC=0, write MTIME_LO=5 on a tick cycle. The next read returns 5 plus the cycles elapsed since the write; the tick is dropped.
  - Assert `reset` between edges. `mti`, `data_o` and `mtime` go to 0 immediately.
